// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: constants and types shared by the program loader and the
// core's instruction-memory declaration.
//   DEPTH : instruction-memory words (largest legal image)
//   AW    : instruction-memory address width
//   IW    : instruction word width (multiple of 8)
//   BPW   : bytes per instruction word
//   BCW   : width of the per-word byte counter
//   state_t : loader FSM states
package prog_loader_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 32;
  localparam int BPW   = IW / 8;
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_asm.sv
// prog_loader_asm: byte-to-word assembler for the program loader.
// Shifts accepted bytes into a word register (big-endian: the first byte of a
// word ends up in the MSBs), counts bytes within the current word and keeps
// the running XOR checksum of all data bytes of the frame.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart a frame (word, byte count and checksum to zero)
//   shift     : a data byte is accepted this cycle
//   data      : the accepted byte
//   word      : assembled word (complete the cycle after word_full && shift)
//   csum      : XOR of all data bytes since clear
//   word_full : the next shifted byte completes the current word
module prog_loader_asm
  import prog_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          shift,
  input  logic [7:0]    data,
  output logic [IW-1:0] word,
  output logic [7:0]    csum,
  output logic          word_full
);

  logic [BCW-1:0] byte_cnt;

  assign word_full = (byte_cnt == BCW'(BPW - 1));

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word     <= '0;
      csum     <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      word     <= (word << 8) | IW'(data);
      csum     <= csum ^ data;
      byte_cnt <= word_full ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads the core's instruction memory from a host byte stream
// and holds the core in reset until a checksum-verified image is in place.
// Frame: header N (word count), N*BPW big-endian data bytes, one XOR
// checksum byte over the data bytes.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request a (re)load; honoured in IDLE, RUN and ERR only
//   s_valid, s_ready, s_data : byte stream from the host
//   im_we, im_addr, im_wdata : instruction-memory write port
//   core_rst  : core reset, low only in RUN
//   busy      : a frame is being received
//   done      : one-cycle pulse when the image is verified
//   err       : sticky error, high in ERR
// All outputs are registered; s_ready depends only on the state register.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state;
  state_t        state_nxt;
  logic [AW:0]   n_words;   // one bit wider than addr so N == DEPTH fits
  logic [AW-1:0] addr;
  logic [7:0]    csum;
  logic          accept;
  logic          hdr_bad;
  logic          last_word;
  logic          csum_ok;
  logic          asm_clear;
  logic          asm_shift;
  logic          word_full;

  assign accept    = s_valid && s_ready;
  assign hdr_bad   = (s_data == 8'd0) || (s_data > 8'(DEPTH));
  assign last_word = ({1'b0, addr} == n_words - (AW + 1)'(1));
  assign csum_ok   = (s_data == csum);
  assign asm_clear = (state == ST_HDR) && accept;
  assign asm_shift = (state == ST_DATA) && accept;

  // The assembler's word register is already a register holding the
  // complete word throughout the WRITE cycle, so it drives im_wdata directly.
  prog_loader_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .shift     (asm_shift),
    .data      (s_data),
    .word      (im_wdata),
    .csum      (csum),
    .word_full (word_full)
  );

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_RUN, ST_ERR: if (start) state_nxt = ST_HDR;
      ST_HDR:   if (accept) state_nxt = hdr_bad ? ST_ERR : ST_DATA;
      ST_DATA:  if (accept && word_full) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = last_word ? ST_CSUM : ST_DATA;
      ST_CSUM:  if (accept) state_nxt = csum_ok ? ST_RUN : ST_ERR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register (e.g. done and the core_rst fall coincide with
  // entry to RUN).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      n_words  <= '0;
      addr     <= '0;
      s_ready  <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      s_ready  <= (state_nxt inside {ST_HDR, ST_DATA, ST_CSUM});
      busy     <= (state_nxt inside {ST_HDR, ST_DATA, ST_WRITE, ST_CSUM});
      core_rst <= (state_nxt != ST_RUN);
      err      <= (state_nxt == ST_ERR);
      done     <= (state == ST_CSUM) && (state_nxt == ST_RUN);
      im_we    <= (state_nxt == ST_WRITE);

      if ((state == ST_DATA) && (state_nxt == ST_WRITE)) im_addr <= addr;

      if (asm_clear) begin
        n_words <= s_data[AW:0];
        addr    <= '0;
      end else if (state == ST_WRITE) begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that writes the core's 16-entry, 32-bit instruction memory from a byte-stream host link and holds the core in reset until a verified image is in place. It is the writer side of the instruction-memory interface the core fetches from. It sits between the host/debug byte channel and the instruction-memory write port, and drives the core's reset.

## Interface
- DEPTH, 16: instruction-memory words; the largest legal word count.
- AW, 4: instruction-memory address width; log2(DEPTH).
- IW, 32: instruction word width; a multiple of 8.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, RUN or ERR.
- s_valid  in  1  a byte is offered on s_data.
- s_ready  out  1  the loader can accept a byte; a byte transfers when s_valid and s_ready are both high.
- s_data  in  8  byte from the host.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  AW  write address.
- im_wdata  out  IW  write data.
- core_rst  out  1  reset to the core; high except in RUN.
- busy  out  1  high in HDR, DATA, WRITE and CSUM.
- done  out  1  one-cycle pulse when the image is verified.
- err  out  1  sticky error flag; high in ERR.

## Operation
- Frame format, in byte order:
  - Header byte N, the word count.
  - N×(IW/8) data bytes, big-endian per word (first byte goes to bits [IW-1:IW-8]).
  - One checksum byte: the XOR of all data bytes (the header is excluded).
- States:
  - IDLE: s_ready=0, core_rst=1. start → HDR.
  - HDR: s_ready=1. On a byte, latch N and clear addr, byte_cnt and csum.
    - N==0 or N>DEPTH → ERR.
    - Otherwise → DATA.
  - DATA: s_ready=1. Each byte shifts into the word register (shift left 8, new byte in LSBs) and XORs into csum.
    - On the (IW/8)th byte of a word → WRITE.
  - WRITE: s_ready=0. im_we=1, im_addr=addr, im_wdata=word. addr increments.
    - If addr==N-1 → CSUM.
    - Otherwise → DATA.
  - CSUM: s_ready=1. On a byte:
    - byte==csum → RUN, with a done pulse in the same cycle as the transition.
    - Otherwise → ERR.
  - RUN: core_rst=0. start → HDR and reasserts core_rst in the same cycle.
  - ERR: err=1, core_rst=1. start → HDR and clears err.
- start while busy is ignored.
- s_valid while s_ready is low is ignored. The byte is not consumed; the host must hold it.
- Memory words at addresses ≥N are not touched.
- Words already written by a failed load stay in memory. core_rst stays high, so they are never executed.

## Timing
- Reset values:
  - state=IDLE.
  - s_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - core_rst=1, busy=0, done=0, err=0.
- All outputs are registered. s_ready is a function of the registered state only; it has no combinational path from s_valid.
- The word write occurs the cycle after its last byte is accepted. That cycle has s_ready=0, so each word costs at least IW/8+1 cycles.
- The first byte can be accepted the cycle after start is sampled.
- Minimum full-image time: 1 + N×(IW/8+1) + 1 accepted-byte cycles after HDR entry. For N=16 this is 82 cycles.
- done: high for exactly one cycle. core_rst falls in that same cycle.
- Reset mid-operation:
  - Next cycle the block is in IDLE with core_rst=1 and im_we=0.
  - No partial word is written.
  - Memory contents are not cleared.
- rst has priority over start. rst and start sampled in the same cycle → IDLE.

## Structure
- A shared package holds:
  - the state encoding (IDLE, HDR, DATA, WRITE, CSUM, RUN, ERR);
  - the DEPTH, AW and IW defaults, kept common with the core's memory declaration;
  - the byte-per-word constant IW/8.
- One sub-module is natural: prog_loader_asm. It contains the byte-to-word shift register, the byte counter and the XOR checksum accumulator, with clear, shift-enable and word_full outputs.
- The FSM and address counter stay in prog_loader.

## Test plan
- Good image, N=2, words 32'h0840_0005 and 32'h1084_0003:
  - Checksum = XOR of the 8 data bytes.
  - Required: im_we pulses at addr 0 and addr 1 with those exact words, done pulses once, core_rst goes low, busy=0.
- Bad checksum, same image with the checksum byte XORed with 8'h01:
  - Required: both words are written, err=1, core_rst stays 1, no done pulse.
  - Then start plus a good frame clears err and reaches RUN.
- Header 0 and header 17:
  - Required: immediate ERR after the header byte, no im_we, core_rst=1.
- Backpressure and gaps:
  - Random s_valid deassertion, and s_valid held through each WRITE cycle.
  - Required: no byte lost or duplicated, s_ready=0 in WRITE, final words match.
- Reset mid-load: rst asserted after 6 data bytes of an N=4 frame.
  - Required: IDLE next cycle, only word 0 written, core_rst=1.
  - A subsequent full load completes normally.
- Reload from RUN:
  - After a successful load, start.
  - Required: core_rst rises the same cycle, busy=1, and a new N=1 image is written at addr 0.
  - start pulsed during DATA is ignored.
